if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction buffer between fetch_stage and decode_stage.
- Captures {instruction, pc, pc+4} produced by fetch into a small FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Decouples fetch from decode stalls (backpressure via IF_ready_o, which gates the fetch PC write enable).
- Discards all buffered entries on a taken branch/jump flush.

Parameters:
- DATA_WIDTH, 32 (from defines package): width of instruction/pc fields.
- DEPTH, 4: number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH): derived pointer width, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IF_valid_i  input  1  fetch presents a valid instruction this cycle.
- IF_instruction_i  input  DATA_WIDTH  fetched instruction.
- IF_pc_i  input  DATA_WIDTH  PC of fetched instruction.
- IF_pc_plus4_i  input  DATA_WIDTH  PC+4 of fetched instruction.
- IF_ready_o  output  1  queue can accept; drives fetch IF_pc_write_en_i.
- ID_flush_i  input  1  taken branch/jump; discard all entries.
- ID_ready_i  input  1  decode accepts head entry (low = hazard stall).
- ID_valid_o  output  1  head entry valid.
- ID_instruction_o  output  DATA_WIDTH  head instruction; NOP when empty.
- ID_pc_o  output  DATA_WIDTH  head PC; 0 when empty.
- ID_pc_plus4_o  output  DATA_WIDTH  head PC+4; 0 when empty.
- ID_count_o  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: ID_valid_o=0, ID_instruction_o=32'h00000013, ID_pc_o=0, ID_pc_plus4_o=0, IF_ready_o=1, ID_count_o=0.
  - Storage contents need not be reset.
  - Reset mid-operation drops all entries immediately.
- push = IF_valid_i && IF_ready_o.
- pop = ID_valid_o && ID_ready_i.
- IF_ready_o = (count != DEPTH). Combinational from count only; no push-when-full even with a same-cycle pop.
- ID_valid_o = (count != 0).
- Head fields are driven combinationally from storage[rd_ptr] (first-word fall-through).
  - When empty: NOP 32'h00000013 and zero PCs, regardless of stale storage.
- Latency: an entry pushed at edge N is visible on ID_* after edge N (one cycle, push to head).
  - No same-cycle bypass from IF_* to ID_*.
- Per rising edge, priority flush > push/pop:
  - ID_flush_i=1: count=0, rd_ptr=wr_ptr. Same-cycle push and pop are both ignored.
  - Push only: write entry at wr_ptr, wr_ptr+1, count+1.
  - Pop only: rd_ptr+1, count-1.
  - Push and pop (only possible when 0<count<DEPTH): write and advance both pointers, count unchanged.
  - Neither: hold all state.
- Pointers are PTR_W bits and wrap modulo DEPTH naturally; count is tracked separately (PTR_W+1 bits).
- Full: IF_ready_o=0, so fetch holds PC; IF_* inputs are ignored.
- Empty: a pop cannot occur; ID_ready_i is don't-care.
- Flush while full: the next cycle is empty and IF_ready_o=1.
- Flush while empty: no effect beyond pointer alignment.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No push when IF_ready_o=0.

Decomposition:
- Package defines:
  - Add NOP_INSTR = 32'h00000013.
  - Add typedef struct packed {instruction, pc, pc_plus4} if_id_entry_t, each DATA_WIDTH.
- Sub-module fetch_buffer_mem: DEPTH x if_id_entry_t register array with one synchronous write port and one asynchronous read port; no reset.
- if_id_queue holds the pointers, count, handshake logic and empty-output muxing.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> ID_valid_o=0, ID_instruction_o=00000013, ID_pc_o=0, IF_ready_o=1, ID_count_o=0.
- Fill with decode stalled: ID_ready_i=0; push instr 1,2,3,4 at pc 0,4,8,C -> count=4, IF_ready_o=0. A 5th push (instr 5) is ignored. Head stays instr 1, pc 0, pc+4 4.
- Drain in order: then ID_ready_i=1 for 4 cycles -> heads seen are 1/0, 2/4, 3/8, 4/C. Then ID_valid_o=0 and NOP output.
- Streaming: push every cycle with ID_ready_i=1 for 10 cycles (instr = pc/4+1) -> count stays 1 after the first push. Output order is preserved across pointer wrap (pc 0..0x24).
- Flush: with 3 entries queued, assert ID_flush_i together with IF_valid_i (instr 41, pc 100) -> next cycle count=0, ID_valid_o=0. Entry 41 is not stored. The following push of 41/100 appears at head one cycle later.
- Async reset mid-stream: drop rst_n between clock edges while count=2 -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_id_queue_pkg : shared types and constants for the IF->ID queue (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package if_id_queue_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- what decode sees whenever the queue is empty
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } q_op_e;

    function automatic q_op_e op_decode(input logic push, input logic pop);
        q_op_e op;
        op = OP_IDLE;
        if (push && pop) begin
            op = OP_BOTH;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_queue_fetch_buffer_mem.sv
// ----------------------------------------------------------------------------
// fetch_buffer_mem : DEPTH-entry register file, sync write / async read (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_buffer_mem
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_addr,
    input  if_id_entry_t       wr_data,
    input  logic [PTR_W-1:0]   rd_addr,
    output if_id_entry_t       rd_data
);

    if_id_entry_t storage [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_addr] <= wr_data;
        end
    end

    assign rd_data = storage[rd_addr];

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue : fall-through instruction FIFO between fetch and decode (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IF_valid_i,
    input  logic [DATA_WIDTH-1:0] IF_instruction_i,
    input  logic [DATA_WIDTH-1:0] IF_pc_i,
    input  logic [DATA_WIDTH-1:0] IF_pc_plus4_i,
    output logic                  IF_ready_o,
    input  logic                  ID_flush_i,
    input  logic                  ID_ready_i,
    output logic                  ID_valid_o,
    output logic [DATA_WIDTH-1:0] ID_instruction_o,
    output logic [DATA_WIDTH-1:0] ID_pc_o,
    output logic [DATA_WIDTH-1:0] ID_pc_plus4_o,
    output logic [PTR_W:0]        ID_count_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic             mem_we;
    q_op_e            op;
    if_id_entry_t     wr_entry;
    if_id_entry_t     head;

    // Ready looks only at count, so a full queue refuses even with a same-cycle pop
    assign IF_ready_o = (count != FULL_COUNT);
    assign ID_valid_o = (count != '0);
    assign push       = IF_valid_i && IF_ready_o;
    assign pop        = ID_valid_o && ID_ready_i;
    assign op         = op_decode(push, pop);
    assign mem_we     = push && !ID_flush_i;

    assign wr_entry.instruction = IF_instruction_i;
    assign wr_entry.pc          = IF_pc_i;
    assign wr_entry.pc_plus4    = IF_pc_plus4_i;

    fetch_buffer_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Flush realigns rd_ptr onto wr_ptr rather than zeroing both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ID_flush_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
                OP_POP: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
                OP_BOTH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    assign ID_instruction_o = ID_valid_o ? head.instruction : NOP_INSTR;
    assign ID_pc_o          = ID_valid_o ? head.pc          : '0;
    assign ID_pc_plus4_o    = ID_valid_o ? head.pc_plus4    : '0;
    assign ID_count_o       = count;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count <= FULL_COUNT)
                else $error("if_id_queue: occupancy above DEPTH");
            assert (!(mem_we && (count == FULL_COUNT)))
                else $error("if_id_queue: write while full");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue : directed + random checks of if_id_queue against a queue model
// ----------------------------------------------------------------------------
`default_nettype none

module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        IF_valid_i;
    logic [31:0] IF_instruction_i;
    logic [31:0] IF_pc_i;
    logic [31:0] IF_pc_plus4_i;
    logic        IF_ready_o;
    logic        ID_flush_i;
    logic        ID_ready_i;
    logic        ID_valid_o;
    logic [31:0] ID_instruction_o;
    logic [31:0] ID_pc_o;
    logic [31:0] ID_pc_plus4_o;
    logic [2:0]  ID_count_o;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
    } model_entry_t;

    model_entry_t mq[$];
    int errors = 0;
    int checks = 0;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IF_valid_i       (IF_valid_i),
        .IF_instruction_i (IF_instruction_i),
        .IF_pc_i          (IF_pc_i),
        .IF_pc_plus4_i    (IF_pc_plus4_i),
        .IF_ready_o       (IF_ready_o),
        .ID_flush_i       (ID_flush_i),
        .ID_ready_i       (ID_ready_i),
        .ID_valid_o       (ID_valid_o),
        .ID_instruction_o (ID_instruction_o),
        .ID_pc_o          (ID_pc_o),
        .ID_pc_plus4_o    (ID_pc_plus4_o),
        .ID_count_o       (ID_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    // Expected outputs follow from the model queue alone: head is the oldest entry
    task automatic check_outputs(input string tag);
        logic [31:0] e_ins, e_pc, e_pc4;
        if (mq.size() == 0) begin
            e_ins = 32'h0000_0013;
            e_pc  = 32'h0;
            e_pc4 = 32'h0;
        end else begin
            e_ins = mq[0].ins;
            e_pc  = mq[0].pc;
            e_pc4 = mq[0].pc4;
        end
        check({tag, ".valid"}, {31'd0, ID_valid_o}, {31'd0, mq.size() != 0});
        check({tag, ".ready"}, {31'd0, IF_ready_o}, {31'd0, mq.size() != DEPTH});
        check({tag, ".count"}, {29'd0, ID_count_o}, 32'(mq.size()));
        check({tag, ".instr"}, ID_instruction_o, e_ins);
        check({tag, ".pc"}, ID_pc_o, e_pc);
        check({tag, ".pc4"}, ID_pc_plus4_o, e_pc4);
    endtask

    // One clock: drive at negedge, check current outputs, advance the model for the coming edge
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic fl, input logic rdy);
        model_entry_t e;
        bit do_push, do_pop;
        @(negedge clk);
        IF_valid_i       = v;
        IF_instruction_i = ins;
        IF_pc_i          = pc;
        IF_pc_plus4_i    = pc + 32'd4;
        ID_flush_i       = fl;
        ID_ready_i       = rdy;
        check_outputs(tag);
        if (fl) begin
            mq.delete();
        end else begin
            do_push = v && (mq.size() < DEPTH);
            do_pop  = rdy && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.ins = ins;
                e.pc  = pc;
                e.pc4 = pc + 32'd4;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        IF_valid_i       = 1'b0;
        IF_instruction_i = 32'h0;
        IF_pc_i          = 32'h0;
        IF_pc_plus4_i    = 32'h0;
        ID_flush_i       = 1'b0;
        ID_ready_i       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Fill with decode stalled; fifth push must be refused
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'(i + 1), 32'(4 * i), 1'b0, 1'b0);
        step("full_push", 1'b1, 32'd5, 32'h10, 1'b0, 1'b0);
        step("full_hold", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step("drained", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) step("stream", 1'b1, 32'(i + 1), 32'(4 * i), 1'b0, 1'b1);
        step("stream_end", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step("stream_idle", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Flush with a concurrent push; the push is discarded
        for (int i = 0; i < 3; i++) step("preflush", 1'b1, 32'(20 + i), 32'(64 + 4 * i), 1'b0, 1'b0);
        step("flush", 1'b1, 32'd41, 32'd100, 1'b1, 1'b1);
        step("post_flush", 1'b1, 32'd41, 32'd100, 1'b0, 1'b0);
        step("refill", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step("refill_done", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Flush while full
        for (int i = 0; i < 4; i++) step("fill2", 1'b1, 32'(30 + i), 32'(200 + 4 * i), 1'b0, 1'b0);
        step("flush_full", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step("after_flush_full", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Async reset between edges with two entries queued
        step("pre_rst_a", 1'b1, 32'd50, 32'h300, 1'b0, 1'b0);
        step("pre_rst_b", 1'b1, 32'd51, 32'h304, 1'b0, 1'b0);
        @(negedge clk);
        IF_valid_i = 1'b0;
        check_outputs("pre_rst");
        rst_n = 1'b0;
        #1;
        mq.delete();
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 9) < 7),
                 $urandom(),
                 $urandom() & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 9) < 5));
        end
        step("final", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
